rot_frame_buffer_db: RTL
========================

Name: rot_frame_buffer_db

Overview:
Double-buffered polar voxel store for the rotating 3D display. The voxel generator writes single (theta, radius, y) voxels into a back bank. The LED scan side reads whole 64-bit radial rows from a front bank. A swap request exchanges the banks, and the new back bank is then cleared automatically. Sits between the voxel rasteriser and the rotational LED driver, replacing the single-bank frame buffer.

Parameters:
ROTATIONAL_RES, 32, number of theta slices per revolution (power of 2, ≤256).
NUM_ROWS, 64, y rows per slice (power of 2, ≤256).
ROW_WIDTH, 64, radial voxels per row (≤256).
Derived: DEPTH = ROTATIONAL_RES*NUM_ROWS; AW = $clog2(DEPTH).

Ports:
clk_in  input  1  system clock
rst_in  input  1  reset, asynchronous, active-low
new_data  input  1  voxel write strobe
set_value  input  1  1 = set voxel bit, 0 = clear voxel bit
theta  input  8  slice index of the write
radius  input  8  bit index within the row
y  input  8  row index within the slice
swap_req  input  1  request a front/back exchange (level; sampled per rules below)
addr_in  input  AW  read row address = theta*NUM_ROWS + y
wr_ready  output  1  back bank accepts writes this cycle
data_ready  output  1  1-cycle pulse: a write was committed
dropped  output  1  1-cycle pulse: a write strobe was rejected
swap_ack  output  1  1-cycle pulse: swap took effect
active_bank  output  1  index of the current front bank
row_out  output  ROW_WIDTH  front-bank row at addr_in

Behaviour:
- Reset (rst_in=0, async): all outputs 0, active_bank=0, swap_pending=0, FSM=INIT.
- FSM states:
  - INIT: clears both banks, one row per bank per cycle, DEPTH cycles. Then goes to IDLE.
  - IDLE: accepts writes and swaps.
  - CLEAR: clears the back bank, one row per cycle, DEPTH cycles. Then goes to IDLE.
- wr_ready=1 only in IDLE.
- Write acceptance: new_data=1 with wr_ready=1 is accepted at that edge.
  - In range (theta<ROTATIONAL_RES, y<NUM_ROWS, radius<ROW_WIDTH): modify bit [radius] of back-bank row theta*NUM_ROWS+y only. data_ready=1 in the next cycle.
  - Out of range: no memory change. dropped=1 in the next cycle.
- new_data=1 with wr_ready=0: ignored. dropped=1 in the next cycle.
- Throughput is one write per cycle. Back-to-back writes to the same row must all land (no lost read-modify-write). Duplicate writes are idempotent.
- Swap in IDLE: swap_req=1 at edge N:
  - active_bank toggles at N+1; swap_ack=1 in cycle N+1.
  - FSM enters CLEAR at N+1.
  - A write accepted at edge N lands in the old back bank, i.e. it is visible in the new front bank.
- swap_req=1 in INIT or CLEAR: sets swap_pending. It is serviced on the first IDLE edge as if swap_req had been seen there. Multiple requests collapse into one.
- Read path: row_out registered, 1-cycle latency from addr_in. It always reads the bank indicated by active_bank at the sampling edge.
  - addr_in ≥ DEPTH → row_out=0.
  - During INIT → row_out=0.
  - Reads of the front bank are never affected by writes or by clearing.
- A reset asserted mid-operation aborts any write or clear. After release the FSM restarts INIT, and no stale data is visible.
- Indices are unsigned. The theta*NUM_ROWS+y product is computed at AW bits after range checking, so it never wraps.

Test Plan:
- Reset release → wr_ready=0 for 2048 cycles, then wr_ready=1. Every addr 0..2047 reads row_out=0. active_bank=0.
- Write (theta=3, y=5, radius=10, set=1), then swap → swap_ack 1 cycle later, active_bank=1. addr_in=197 gives row_out=0x400 one cycle later. data_ready pulsed once.
- Writes radius=0,1,63 to theta=0, y=0 on consecutive cycles, then swap → row 0 = 0x8000_0000_0000_0003. Clear radius=1 then swap twice → the value is seen, then the re-cleared bank reads 0.
- Write theta=32 / y=64 / radius=64 → dropped pulse each time, no row changes. new_data during CLEAR → dropped, back bank unchanged.
- swap_req asserted during CLEAR → swap_ack exactly 1 cycle after the 2048-cycle clear ends.
- Simultaneous new_data+swap_req in IDLE → the written voxel appears in the new front bank.
- rst_in pulsed low mid-CLEAR → outputs 0 immediately, then full INIT.

Source files
------------

// File: rtl/rot_frame_buffer_db.sv
// Double-buffered polar voxel store for the rotating display.
// The rasteriser sets/clears single voxels in the back bank while the LED
// scan side reads whole radial rows from the front bank. A swap exchanges
// the banks and the new back bank is then wiped one row per cycle.
module rot_frame_buffer_db #(
  parameter  int ROTATIONAL_RES = 32,
  parameter  int NUM_ROWS       = 64,
  parameter  int ROW_WIDTH      = 64,
  localparam int DEPTH          = ROTATIONAL_RES * NUM_ROWS,
  localparam int AW             = $clog2(DEPTH)
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic                 new_data,
  input  logic                 set_value,
  input  logic [7:0]           theta,
  input  logic [7:0]           radius,
  input  logic [7:0]           y,
  input  logic                 swap_req,
  input  logic [AW-1:0]        addr_in,
  output logic                 wr_ready,
  output logic                 data_ready,
  output logic                 dropped,
  output logic                 swap_ack,
  output logic                 active_bank,
  output logic [ROW_WIDTH-1:0] row_out
);

  localparam int RW = (ROW_WIDTH > 1) ? $clog2(ROW_WIDTH) : 1;

  // Limits widened by one bit so a parameter of 256 still compares correctly.
  localparam logic [8:0]    THETA_LIM = 9'(ROTATIONAL_RES);
  localparam logic [8:0]    Y_LIM     = 9'(NUM_ROWS);
  localparam logic [8:0]    R_LIM     = 9'(ROW_WIDTH);
  localparam logic [AW:0]   DEPTH_LIM = (AW + 1)'(DEPTH);
  localparam logic [AW-1:0] LAST_ROW  = AW'(DEPTH - 1);

  typedef enum logic [1:0] {
    ST_INIT,
    ST_IDLE,
    ST_CLEAR
  } state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d;
  logic          active_bank_q, active_bank_d;
  logic          swap_pending_q, swap_pending_d;
  logic          data_ready_q, data_ready_d;
  logic          dropped_q, dropped_d;
  logic          swap_ack_q, swap_ack_d;
  logic          rd_zero_q;
  logic          rd_sel_q;

  logic          in_range;
  logic          wr_en;
  logic          clr_all;
  logic          clr_back;
  logic [AW-1:0] wr_addr;
  logic [RW-1:0] wr_bit;

  // Range check first; the address is only meaningful once all indices fit.
  assign in_range = ({1'b0, theta}  < THETA_LIM) &&
                    ({1'b0, y}      < Y_LIM)     &&
                    ({1'b0, radius} < R_LIM);
  assign wr_addr  = AW'(theta) * AW'(NUM_ROWS) + AW'(y);
  assign wr_bit   = radius[RW-1:0];

  assign wr_ready = (state_q == ST_IDLE);
  assign wr_en    = new_data && wr_ready && in_range;
  assign clr_all  = (state_q == ST_INIT);
  assign clr_back = (state_q == ST_CLEAR);

  // Next-state logic: clear sequencing, swap servicing and write status pulses.
  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    active_bank_d  = active_bank_q;
    swap_pending_d = swap_pending_q;
    data_ready_d   = 1'b0;
    dropped_d      = 1'b0;
    swap_ack_d     = 1'b0;

    case (state_q)
      ST_INIT, ST_CLEAR: begin
        // Requests while busy collapse into a single deferred swap.
        if (swap_req) swap_pending_d = 1'b1;
        if (cnt_q == LAST_ROW) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + AW'(1);
        end
      end
      ST_IDLE: begin
        if (swap_req || swap_pending_q) begin
          active_bank_d  = ~active_bank_q;
          swap_pending_d = 1'b0;
          swap_ack_d     = 1'b1;
          state_d        = ST_CLEAR;
          cnt_d          = '0;
        end
      end
      default: begin
        state_d = ST_INIT;
        cnt_d   = '0;
      end
    endcase

    if (new_data) begin
      if (wr_en) data_ready_d = 1'b1;
      else       dropped_d    = 1'b1;
    end
  end

  // Control registers; reset restarts the full two-bank wipe.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q        <= ST_INIT;
      cnt_q          <= '0;
      active_bank_q  <= 1'b0;
      swap_pending_q <= 1'b0;
      data_ready_q   <= 1'b0;
      dropped_q      <= 1'b0;
      swap_ack_q     <= 1'b0;
      rd_zero_q      <= 1'b1;
      rd_sel_q       <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      active_bank_q  <= active_bank_d;
      swap_pending_q <= swap_pending_d;
      data_ready_q   <= data_ready_d;
      dropped_q      <= dropped_d;
      swap_ack_q     <= swap_ack_d;
      // Bank choice and blanking are frozen at the read edge alongside the data.
      rd_zero_q      <= clr_all || ({1'b0, addr_in} >= DEPTH_LIM);
      rd_sel_q       <= active_bank_q;
    end
  end

  // Two banks; each is written only while it is the back bank (or during INIT).
  // A bit-granular write means back-to-back writes to one row never race.
  for (genvar gi = 0; gi < 2; gi++) begin : g_bank
    logic [ROW_WIDTH-1:0] mem [DEPTH];
    logic [ROW_WIDTH-1:0] rd_q;
    logic                 is_back;

    assign is_back = (active_bank_q != 1'(gi));

    // Row wipe has priority; otherwise apply the accepted voxel write.
    always_ff @(posedge clk_in) begin
      if (clr_all || (clr_back && is_back)) begin
        mem[cnt_q] <= '0;
      end else if (wr_en && is_back) begin
        mem[wr_addr][wr_bit] <= set_value;
      end
    end

    // Registered read port of this bank.
    always_ff @(posedge clk_in) begin
      rd_q <= mem[addr_in];
    end
  end

  assign row_out     = rd_zero_q ? '0 : (rd_sel_q ? g_bank[1].rd_q : g_bank[0].rd_q);
  assign data_ready  = data_ready_q;
  assign dropped     = dropped_q;
  assign swap_ack    = swap_ack_q;
  assign active_bank = active_bank_q;

endmodule
